// File: rtl/slow_clock_period_monitor.sv
// Consumer-side checker for a slow divided clock: synchronizes it, pulses tick on each
// rising edge, measures its period in clk_50MHz cycles and reports lock / range / stuck status.
module slow_clock_period_monitor #(
  parameter int unsigned EXP_PERIOD = 80000,
  parameter int unsigned TOL        = 800,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 160000
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        clk_slow_in,
  input  logic        enable,
  output logic        tick,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        fault_range,
  output logic        fault_stuck,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    TRACK   = 2'b10,
    LOCKED  = 2'b11
  } state_e;

  localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  // Bounds are 33 bits so EXP_PERIOD+TOL cannot wrap; the low bound floors at zero.
  localparam logic [32:0] LO_BOUND  = (EXP_PERIOD > TOL) ? 33'(EXP_PERIOD - TOL) : 33'd0;
  localparam logic [32:0] HI_BOUND  = 33'(EXP_PERIOD) + 33'(TOL);
  localparam logic [32:0] TIMEOUT_W = 33'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_W  = GW'(LOCK_COUNT);

  logic [2:0]    sync_q, sync_d;
  logic          tick_q, tick_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   period_q, period_d;
  logic          pv_q, pv_d;
  logic          fr_q, fr_d;
  logic          fs_q, fs_d;
  logic [GW-1:0] good_q, good_d;
  state_e        state_q, state_d;

  logic          rise;
  logic [32:0]   cnt_inc;
  logic [31:0]   cnt_sat;
  logic          in_range;
  logic          timeout_hit;
  logic [GW-1:0] good_inc;

  // sync_q[0] is the metastability stage; rise is taken between stages 1 and 2.
  assign rise        = sync_q[1] & ~sync_q[2];
  assign cnt_inc     = {1'b0, cnt_q} + 33'd1;
  assign cnt_sat     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign in_range    = (cnt_inc >= LO_BOUND) && (cnt_inc <= HI_BOUND);
  assign timeout_hit = (cnt_inc == TIMEOUT_W);
  assign good_inc    = (good_q == LOCK_W) ? good_q : good_q + GW'(1);

  always_comb begin
    sync_d   = {sync_q[1:0], clk_slow_in};
    tick_d   = rise;
    state_d  = state_q;
    cnt_d    = rise ? 32'd0 : cnt_sat;
    period_d = period_q;
    pv_d     = pv_q;
    fr_d     = fr_q;
    fs_d     = fs_q;
    good_d   = good_q;

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = 32'd0;
      good_d   = '0;
      period_d = 32'd0;
      pv_d     = 1'b0;
      fr_d     = 1'b0;
      fs_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          cnt_d   = 32'd0;
          good_d  = '0;
        end
        ACQUIRE: begin
          // The first edge only seeds the counter; there is no previous edge to measure from.
          if (rise) begin
            state_d = TRACK;
          end else if (timeout_hit) begin
            fs_d   = 1'b1;
            pv_d   = 1'b0;
            good_d = '0;
            cnt_d  = 32'd0;
          end
        end
        TRACK, LOCKED: begin
          if (rise) begin
            period_d = cnt_inc[32] ? 32'hFFFF_FFFF : cnt_inc[31:0];
            pv_d     = 1'b1;
            if (in_range) begin
              good_d = good_inc;
              if (state_q == TRACK && good_inc == LOCK_W) state_d = LOCKED;
            end else begin
              good_d = '0;
              if (state_q == LOCKED) begin
                state_d = TRACK;
                fr_d    = 1'b1;
              end
            end
          end else if (timeout_hit) begin
            state_d = ACQUIRE;
            fs_d    = 1'b1;
            pv_d    = 1'b0;
            good_d  = '0;
            cnt_d   = 32'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 3'b000;
      tick_q   <= 1'b0;
      cnt_q    <= 32'd0;
      period_q <= 32'd0;
      pv_q     <= 1'b0;
      fr_q     <= 1'b0;
      fs_q     <= 1'b0;
      good_q   <= '0;
      state_q  <= IDLE;
    end else begin
      sync_q   <= sync_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      fr_q     <= fr_d;
      fs_q     <= fs_d;
      good_q   <= good_d;
      state_q  <= state_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == LOCKED);
  assign fault_range  = fr_q;
  assign fault_stuck  = fs_q;
  assign state        = state_q;

endmodule

// File: tb/tb_slow_clock_period_monitor.sv
// Randomized bench for slow_clock_period_monitor with scaled-down timing parameters and
// an event-level reference model (rise-time queue plus per-rise rule application).
module tb_slow_clock_period_monitor;

  localparam int EXP   = 80;
  localparam int TOL   = 8;
  localparam int LOCKN = 4;
  localparam int TMO   = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_slow_in = 1'b0;
  logic        enable = 1'b0;
  logic        tick;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        fault_range;
  logic        fault_stuck;
  logic [1:0]  state;

  slow_clock_period_monitor #(
    .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LOCKN), .TIMEOUT(TMO)
  ) dut (
    .clk_50MHz   (clk),
    .rst_n       (rst_n),
    .clk_slow_in (clk_slow_in),
    .enable      (enable),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .fault_range (fault_range),
    .fault_stuck (fault_stuck),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: rise effect times, and spec-level status recomputed on each edge.
  int   cyc = 0;
  int   rq[$];
  bit   prev_in = 1'b0;
  int   m_st = 0, m_per = 0, m_good = 0, m_ref = 0;
  bit   m_tick = 0, m_pv = 0, m_fr = 0, m_fs = 0;
  logic [38:0] got_v, want_v;

  function automatic logic [38:0] obs_vec();
    return {tick, period_valid, locked, fault_range, fault_stuck, state, period};
  endfunction

  function automatic logic [38:0] exp_vec();
    return {m_tick, m_pv, (m_st == 3), m_fr, m_fs, 2'(m_st), 32'(m_per)};
  endfunction

  function automatic void model_clear();
    rq.delete();
    prev_in = 1'b0;
    m_st = 0; m_per = 0; m_good = 0; m_ref = cyc;
    m_tick = 0; m_pv = 0; m_fr = 0; m_fs = 0;
  endfunction

  function automatic void model_edge(input bit en);
    bit r = 1'b0;
    int p;
    if (rq.size() > 0 && rq[0] == cyc) begin
      r = 1'b1;
      void'(rq.pop_front());
    end
    m_tick = r;
    if (!en) begin
      m_st = 0; m_per = 0; m_pv = 0; m_fr = 0; m_fs = 0; m_good = 0; m_ref = cyc;
    end else if (m_st == 0) begin
      m_st = 1; m_good = 0; m_ref = cyc;
    end else if (r) begin
      if (m_st == 1) begin
        m_st = 2;
      end else begin
        p = cyc - m_ref;
        m_per = p;
        m_pv  = 1;
        if (p >= EXP - TOL && p <= EXP + TOL) begin
          if (m_good < LOCKN) m_good++;
          if (m_st == 2 && m_good == LOCKN) m_st = 3;
        end else begin
          m_good = 0;
          if (m_st == 3) begin m_st = 2; m_fr = 1; end
        end
      end
      m_ref = cyc;
    end else if (cyc - m_ref == TMO) begin
      m_st = 1; m_fs = 1; m_pv = 0; m_good = 0; m_ref = cyc;
    end
  endfunction

  // One clock: drive at negedge, let the edge happen, advance the model.
  task automatic step(input bit v, input bit en);
    @(negedge clk);
    if (v && !prev_in) rq.push_back(cyc + 3);
    prev_in = v;
    clk_slow_in = v;
    enable = en;
    @(posedge clk);
    cyc++;
    #1;
    model_edge(en);
  endtask

  // n cycles with the slow clock high for the first `high` of them; counts cycles off-model.
  task automatic run_cycles(input int n, input int high, input bit en, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step(i < high, en);
      if (obs_vec() !== exp_vec()) begin
        bad++;
        got_v = obs_vec();
        want_v = exp_vec();
      end
    end
  endtask

  task automatic drive_period(input int p, input bit en, output int bad);
    run_cycles(p, int'($urandom_range(p - 1, 1)), en, bad);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clk_slow_in = 1'b0;
    enable = 1'b0;
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    model_edge(1'b0);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clk_slow_in = ~clk_slow_in;
      @(posedge clk);
      #1;
      n_tests++;
      if (obs_vec() !== 39'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h want 0", obs_vec());
      end
    end
    release_reset();
    for (int k = 0; k < 3; k++) begin
      drive_period(int'($urandom_range(30, 10)), 1'b0, bad);
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL idle_ticks: %0d bad cycles got %h want %h", bad, got_v, want_v);
      end
    end
    n_tests++;
    if (state !== 2'b00 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state: got state=%0d pv=%0b want 0/0", state, period_valid);
    end
  endtask

  task automatic test_lock();
    int bad, tot;
    tot = 0;
    for (int k = 0; k < 2; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    n_tests++;
    if (period !== 32'(EXP) || period_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_period: got %0d/%0b want %0d/1", period, period_valid, EXP);
    end
    for (int k = 0; k < 3; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    n_tests++;
    if (tot !== 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock: bad=%0d locked=%0b want 0/1 last got %h want %h", tot, locked, got_v, want_v);
    end
  endtask

  task automatic test_range_fault();
    int bad, tot;
    tot = 0;
    drive_period(EXP + TOL + 1, 1'b1, bad); tot += bad;
    drive_period(EXP, 1'b1, bad); tot += bad;
    n_tests++;
    if (period !== 32'(EXP + TOL + 1) || state !== 2'b10 || fault_range !== 1'b1) begin
      n_fail++;
      $display("FAIL range_fault: got p=%0d st=%0d fr=%0b want %0d/2/1", period, state, fault_range, EXP + TOL + 1);
    end
    for (int k = 0; k < 4; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    n_tests++;
    if (tot !== 0 || locked !== 1'b1 || fault_range !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: bad=%0d locked=%0b fr=%0b want 0/1/1", tot, locked, fault_range);
    end
  endtask

  task automatic test_tol_edges();
    int bad, tot;
    int seq [5] = '{EXP + TOL, EXP - TOL, EXP + TOL, EXP - TOL, EXP + TOL + 1};
    run_cycles(2, 0, 1'b0, tot);
    foreach (seq[k]) begin drive_period(seq[k], 1'b1, bad); tot += bad; end
    n_tests++;
    if (locked !== 1'b1 || period !== 32'(EXP - TOL)) begin
      n_fail++;
      $display("FAIL tol_edges_lock: got locked=%0b p=%0d want 1/%0d", locked, period, EXP - TOL);
    end
    drive_period(EXP, 1'b1, bad); tot += bad;
    n_tests++;
    if (tot !== 0 || locked !== 1'b0 || fault_range !== 1'b1) begin
      n_fail++;
      $display("FAIL tol_edge_over: bad=%0d locked=%0b fr=%0b want 0/0/1", tot, locked, fault_range);
    end
  endtask

  task automatic test_stuck();
    int bad, tot;
    run_cycles(2, 0, 1'b0, tot);
    for (int k = 0; k < 6; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    drive_period(TMO - 1, 1'b1, bad); tot += bad;
    run_cycles(10, 1, 1'b1, bad); tot += bad;
    n_tests++;
    if (fault_stuck !== 1'b0 || period !== 32'(TMO - 1)) begin
      n_fail++;
      $display("FAIL near_timeout: got fs=%0b p=%0d want 0/%0d", fault_stuck, period, TMO - 1);
    end
    run_cycles(TMO, 0, 1'b1, bad); tot += bad;
    n_tests++;
    if (tot !== 0 || fault_stuck !== 1'b1 || state !== 2'b01 || period_valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck: bad=%0d fs=%0b st=%0d pv=%0b lk=%0b want 0/1/1/0/0", tot, fault_stuck, state, period_valid, locked);
    end
  endtask

  task automatic test_enable_drop();
    int bad, tot;
    tot = 0;
    for (int k = 0; k < 3; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    n_tests++;
    if (state !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_drop: got state=%0d want 2", state);
    end
    run_cycles(1, 0, 1'b0, bad); tot += bad;
    n_tests++;
    if (tot !== 0 || state !== 2'b00 || period !== 32'd0 || period_valid !== 1'b0 || fault_stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop: bad=%0d st=%0d p=%0d pv=%0b fs=%0b want all 0", tot, state, period, period_valid, fault_stuck);
    end
  endtask

  task automatic test_async_reset();
    int bad, tot;
    tot = 0;
    for (int k = 0; k < 3; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    run_cycles(20, 10, 1'b1, bad); tot += bad;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_vec() !== 39'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", obs_vec());
    end
    clk_slow_in = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();
    for (int k = 0; k < 6; k++) begin drive_period(EXP, 1'b1, bad); tot += bad; end
    n_tests++;
    if (tot !== 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: bad=%0d locked=%0b want 0/1 last got %h want %h", tot, locked, got_v, want_v);
    end
  endtask

  task automatic test_random();
    int bad, r, p;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) run_cycles(int'($urandom_range(6, 1)), 0, 1'b0, bad);
      else begin
        if (r == 1) p = int'($urandom_range(TMO + 20, EXP + 2 * TOL));
        else        p = int'($urandom_range(EXP + TOL + 2, EXP - TOL - 2));
        drive_period(p, 1'b1, bad);
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL random[%0d]: %0d bad cycles got %h want %h", k, bad, got_v, want_v);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_lock();
    test_range_fault();
    test_tol_edges();
    test_stuck();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
